// File: rtl/ss_shift_engine_if.sv
// Handshake/data bundle for ss_shift_engine: command inputs from the
// controlling master, register contents and burst status back from the engine.
interface ss_shift_engine_if #(
  parameter int WIDTH = 8,
  parameter int LW    = $clog2(WIDTH) + 1
);
  logic             enable;
  logic [1:0]       mode;
  logic             dir;
  logic             sin;
  logic [WIDTH-1:0] pin;
  logic             start;
  logic [LW-1:0]    len;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output enable, mode, dir, sin, pin, start, len,
    input  q, sout, busy, done
  );

  modport slave (
    input  enable, mode, dir, sin, pin, start, len,
    output q, sout, busy, done
  );
endinterface

// File: rtl/ss_shift_engine.sv
// Parametrised shift/rotate/load register with a counted burst-shift controller
// (IDLE -> SHIFT -> DONE) that shifts len bits out while capturing len bits in.
module ss_shift_engine #(
  parameter int WIDTH = 8,
  parameter int LW    = $clog2(WIDTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  ss_shift_engine_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [LW-1:0] WIDTH_L = LW'(WIDTH);
  localparam logic [LW-1:0] ONE_L   = LW'(1);

  state_t           state_r;
  logic [WIDTH-1:0] q_r;
  logic [LW-1:0]    cnt_r;
  logic             dir_r;
  logic             busy_r;
  logic             done_r;

  logic [LW-1:0]    len_clamped_s;
  logic             eff_dir_s;
  logic             exit_bit_s;

  // One-bit shift; dir 0 moves toward bit 0, dir 1 moves toward the MSB.
  function automatic logic [WIDTH-1:0] shift_one(
    input logic [WIDTH-1:0] value,
    input logic             left,
    input logic             fill
  );
    logic [WIDTH-1:0] result;
    if (left) begin
      result = {value[WIDTH-2:0], fill};
    end else begin
      result = {fill, value[WIDTH-1:1]};
    end
    return result;
  endfunction

  // Clamp burst length and pick the direction the exit bit is taken from.
  always_comb begin
    len_clamped_s = bus.len;
    if (bus.len > WIDTH_L) begin
      len_clamped_s = WIDTH_L;
    end else begin
      len_clamped_s = bus.len;
    end

    eff_dir_s = bus.dir;
    if (state_r != ST_IDLE) begin
      eff_dir_s = dir_r;
    end else begin
      eff_dir_s = bus.dir;
    end

    exit_bit_s = q_r[0];
    if (eff_dir_s) begin
      exit_bit_s = q_r[WIDTH-1];
    end else begin
      exit_bit_s = q_r[0];
    end
  end

  // Burst FSM, shift register and counter; every update is gated by enable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      q_r     <= '0;
      cnt_r   <= '0;
      dir_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (bus.enable) begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            // q is deliberately untouched on the start edge.
            dir_r <= bus.dir;
            if (len_clamped_s == '0) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              cnt_r   <= len_clamped_s;
              state_r <= ST_SHIFT;
              busy_r  <= 1'b1;
              done_r  <= 1'b0;
            end
          end else begin
            case (bus.mode)
              2'b00:   q_r <= q_r;
              2'b01:   q_r <= shift_one(q_r, bus.dir, bus.sin);
              2'b10:   q_r <= shift_one(q_r, bus.dir, exit_bit_s);
              2'b11:   q_r <= bus.pin;
              default: q_r <= q_r;
            endcase
          end
        end

        ST_SHIFT: begin
          q_r   <= shift_one(q_r, dir_r, bus.sin);
          cnt_r <= cnt_r - ONE_L;
          if (cnt_r == ONE_L) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_SHIFT;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end

        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end

        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  assign bus.q    = q_r;
  assign bus.sout = exit_bit_s;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_ss_shift_engine.sv
// Directed bench for ss_shift_engine: a burst-level reference model checked on
// every falling edge, plus hand-computed literal expectations for each scenario.
module tb_ss_shift_engine;
  localparam int W  = 8;
  localparam int LW = $clog2(W) + 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ss_shift_engine_if #(.WIDTH(W)) bus ();
  ss_shift_engine #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] m_q;
  int           m_rem;   // shifts still owed by the current burst
  bit           m_done;
  bit           m_dir;

  function automatic logic [W-1:0] mshift(input logic [W-1:0] v, input bit left, input bit b);
    int r;
    if (left) r = ((int'(v) * 2) % 256) + int'(b);
    else      r = (int'(v) / 2) + (int'(b) * 128);
    return W'(r);
  endfunction

  function automatic int clamp(input logic [LW-1:0] l);
    return (int'(l) > W) ? W : int'(l);
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_q <= '0; m_rem <= 0; m_done <= 1'b0; m_dir <= 1'b0;
    end else if (bus.enable) begin
      if (m_done) begin
        m_done <= 1'b0;
      end else if (m_rem > 0) begin
        m_q   <= mshift(m_q, m_dir, bus.sin);
        m_rem <= m_rem - 1;
        if (m_rem == 1) m_done <= 1'b1;
      end else if (bus.start) begin
        m_dir <= bus.dir;
        if (clamp(bus.len) == 0) m_done <= 1'b1;
        else m_rem <= clamp(bus.len);
      end else begin
        case (bus.mode)
          2'b01: m_q <= mshift(m_q, bus.dir, bus.sin);
          2'b10: m_q <= mshift(m_q, bus.dir, bus.dir ? m_q[W-1] : m_q[0]);
          2'b11: m_q <= bus.pin;
          default: m_q <= m_q;
        endcase
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clock) begin
    if (!reset) begin
      bit ed;
      ed = (m_rem > 0 || m_done) ? m_dir : bus.dir;
      check("model_q",    32'(bus.q),    32'(m_q));
      check("model_busy", 32'(bus.busy), 32'(m_rem > 0));
      check("model_done", 32'(bus.done), 32'(m_done));
      check("model_sout", 32'(bus.sout), 32'(ed ? m_q[W-1] : m_q[0]));
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [7:0] pat;
    logic [7:0] sout_exp;
    logic [7:0] held;
    int cnt;

    reset = 1'b1;
    bus.enable = 1'b1; bus.mode = 2'b00; bus.dir = 1'b0; bus.sin = 1'b0;
    bus.pin = '0; bus.start = 1'b0; bus.len = '0;
    #12;
    check("reset_q",    32'(bus.q),    32'h00);
    check("reset_busy", 32'(bus.busy), 32'h0);
    check("reset_done", 32'(bus.done), 32'h0);
    check("reset_sout", 32'(bus.sout), 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Load then shift right
    bus.mode = 2'b11; bus.pin = 8'hA5; bus.dir = 1'b0;
    step();
    check("load_q",    32'(bus.q),    32'hA5);
    check("load_sout", 32'(bus.sout), 32'h1);
    bus.mode = 2'b01; bus.sin = 1'b1;
    step();
    check("shr_q",    32'(bus.q),    32'hD2);
    check("shr_sout", 32'(bus.sout), 32'h0);

    // Rotate left
    bus.mode = 2'b11; bus.pin = 8'h81;
    step();
    bus.mode = 2'b10; bus.dir = 1'b1;
    step();
    check("rol1_q", 32'(bus.q), 32'h03);
    step();
    check("rol2_q", 32'(bus.q), 32'h06);

    // Burst of 8, left, capturing 0x3C MSB first; live dir flipped to prove dir_r is used
    bus.mode = 2'b11; bus.pin = 8'hA5;
    step();
    bus.mode = 2'b00; bus.dir = 1'b1; bus.start = 1'b1; bus.len = LW'(8);
    step();
    bus.start = 1'b0; bus.dir = 1'b0;
    pat = 8'h3C; sout_exp = 8'b1010_0101; cnt = 0;
    for (int k = 0; k < 8; k++) begin
      check("burst_sout", 32'(bus.sout), 32'(sout_exp[7-k]));
      if (bus.busy) cnt++;
      bus.sin = pat[7-k];
      step();
    end
    check("burst_busy_cycles", 32'(cnt), 32'd8);
    check("burst_busy_end", 32'(bus.busy), 32'h0);
    check("burst_done",     32'(bus.done), 32'h1);
    check("burst_q",        32'(bus.q),    32'h3C);
    step();
    check("burst_done_drop", 32'(bus.done), 32'h0);

    // len = 0
    bus.start = 1'b1; bus.len = LW'(0);
    step();
    bus.start = 1'b0;
    check("len0_done", 32'(bus.done), 32'h1);
    check("len0_busy", 32'(bus.busy), 32'h0);
    check("len0_q",    32'(bus.q),    32'h3C);
    step();
    check("len0_done_drop", 32'(bus.done), 32'h0);

    // len = 12 clamps to 8
    bus.start = 1'b1; bus.len = LW'(12); bus.dir = 1'b0; bus.sin = 1'b0;
    step();
    bus.start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20 && bus.busy; i++) begin
      cnt++;
      step();
    end
    check("len12_shifts", 32'(cnt), 32'd8);
    check("len12_done",   32'(bus.done), 32'h1);
    step();

    // Freeze mid-burst for 3 cycles
    bus.mode = 2'b11; bus.pin = 8'hA5;
    step();
    bus.mode = 2'b00; bus.start = 1'b1; bus.len = LW'(8); bus.dir = 1'b0; bus.sin = 1'b1;
    step();
    bus.start = 1'b0;
    cnt = 1;
    step(); step(); cnt += 2;
    held = bus.q;
    bus.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); cnt++;
      check("freeze_q",    32'(bus.q),    32'(held));
      check("freeze_busy", 32'(bus.busy), 32'h1);
    end
    bus.enable = 1'b1;
    for (int i = 0; i < 30 && !bus.done; i++) begin
      step(); cnt++;
    end
    check("freeze_start_to_done", 32'(cnt), 32'd12);
    check("freeze_q_final",       32'(bus.q), 32'hFF);
    step();

    // start and load during busy are ignored
    bus.mode = 2'b11; bus.pin = 8'hA5;
    step();
    bus.mode = 2'b00; bus.start = 1'b1; bus.len = LW'(4); bus.dir = 1'b0; bus.sin = 1'b0;
    step();
    bus.start = 1'b0;
    step();
    bus.start = 1'b1; bus.mode = 2'b11; bus.pin = 8'hFF; bus.dir = 1'b1;
    step();
    bus.start = 1'b0; bus.mode = 2'b00; bus.dir = 1'b0;
    for (int i = 0; i < 10 && !bus.done; i++) step();
    check("ignore_done", 32'(bus.done), 32'h1);
    check("ignore_q",    32'(bus.q),    32'h0A);
    step();
    check("ignore_idle_q",    32'(bus.q),    32'h0A);
    check("ignore_idle_busy", 32'(bus.busy), 32'h0);

    // Asynchronous reset three edges into a burst
    bus.mode = 2'b11; bus.pin = 8'h5A;
    step();
    bus.mode = 2'b00; bus.start = 1'b1; bus.len = LW'(8); bus.dir = 1'b1; bus.sin = 1'b1;
    step();
    bus.start = 1'b0;
    step(); step();
    #2 reset = 1'b1;
    #1;
    check("areset_q",    32'(bus.q),    32'h00);
    check("areset_busy", 32'(bus.busy), 32'h0);
    check("areset_done", 32'(bus.done), 32'h0);
    check("areset_sout", 32'(bus.sout), 32'h0);
    @(posedge clock); #1;
    reset = 1'b0; bus.mode = 2'b00;
    step();
    check("post_reset_q",    32'(bus.q),    32'h00);
    check("post_reset_busy", 32'(bus.busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
